// File: rtl/capture_pkg.sv
// Shared types for the logic-analyser capture sequencer: state encoding,
// sample width and the channel-masking helper.
package capture_pkg;

   localparam int SAMPLE_W = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FILL    = 3'd1,
      ARMED   = 3'd2,
      POST    = 3'd3,
      READOUT = 3'd4
   } state_t;

   function automatic logic [SAMPLE_W-1:0] mask_sample(
      input logic [SAMPLE_W-1:0] s,
      input logic [SAMPLE_W-1:0] m
   );
      return s & m;
   endfunction

endpackage

// File: rtl/sample_ram.sv
// Circular capture buffer: DEPTH x SAMPLE_W, one write port and one read port
// whose data appears one cycle after the read request.
module sample_ram
   import capture_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic                clk,
   input  logic                we,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [SAMPLE_W-1:0] wdata,
   input  logic                re,
   input  logic [ADDR_W-1:0]   raddr,
   output logic [SAMPLE_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [SAMPLE_W-1:0] mem_r [DEPTH];

   // Write port and registered read port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem_r[raddr];
      end
   end

endmodule

// File: rtl/capture_sequencer.sv
// Sequences one capture: pre-trigger fill, armed circular recording, post-trigger
// window, then oldest-first readout over a valid/ready byte stream.
module capture_sequencer
   import capture_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int PRETRIG = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] channel_mask,
   input  logic                arm,
   input  logic                abort,
   input  logic                force_trig,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SAMPLE_W-1:0] out_data,
   output logic                busy,
   output logic                triggered
);

   localparam logic [ADDR_W:0]   CNT_ZERO   = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1'b1);
   localparam logic [ADDR_W:0]   DEPTH_C    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   PRETRIG_C  = (ADDR_W+1)'(PRETRIG);
   localparam logic [ADDR_W:0]   POST_LEN_C = DEPTH_C - PRETRIG_C;
   localparam logic [ADDR_W:0]   LAST_C     = DEPTH_C - CNT_ONE;
   localparam logic [ADDR_W-1:0] PTR_ZERO   = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1'b1);

   state_t              state_r, state_s;
   logic [ADDR_W-1:0]   wr_ptr_r, wr_ptr_s;
   logic [ADDR_W-1:0]   rd_ptr_r, rd_ptr_s;
   logic [ADDR_W:0]     cnt_r, cnt_s, cnt_inc_s;
   logic                prev_any_r;
   logic                triggered_r, triggered_s;
   logic                out_valid_r, out_valid_s;
   logic [SAMPLE_W-1:0] out_data_r, out_data_s;
   logic                rd_pend_r, rd_pend_s;
   logic                busy_r;

   logic                ram_we_s;
   logic                ram_re_s;
   logic [ADDR_W-1:0]   ram_raddr_s;
   logic [SAMPLE_W-1:0] ram_wdata_s;
   logic [SAMPLE_W-1:0] ram_q_s;
   logic                any_s;
   logic                trig_s;
   logic                accept_s;

   assign ram_wdata_s = mask_sample(sample, channel_mask);
   assign any_s       = |ram_wdata_s;
   assign trig_s      = (sample_valid & any_s & ~prev_any_r) | force_trig;
   assign accept_s    = out_valid_r & out_ready;
   assign cnt_inc_s   = cnt_r + CNT_ONE;

   sample_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (ram_we_s),
      .waddr (wr_ptr_r),
      .wdata (ram_wdata_s),
      .re    (ram_re_s),
      .raddr (ram_raddr_s),
      .rdata (ram_q_s)
   );

   // Next-state, pointer, counter and readout handshake decisions
   always_comb begin
      state_s     = state_r;
      wr_ptr_s    = wr_ptr_r;
      rd_ptr_s    = rd_ptr_r;
      cnt_s       = cnt_r;
      triggered_s = triggered_r;
      out_valid_s = out_valid_r;
      out_data_s  = out_data_r;
      rd_pend_s   = rd_pend_r;
      ram_we_s    = 1'b0;
      ram_re_s    = 1'b0;
      ram_raddr_s = rd_ptr_r;

      if (abort) begin
         state_s     = IDLE;
         triggered_s = 1'b0;
         out_valid_s = 1'b0;
         rd_pend_s   = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (arm) begin
                  state_s  = FILL;
                  wr_ptr_s = PTR_ZERO;
                  cnt_s    = CNT_ZERO;
               end else begin
                  state_s = IDLE;
               end
            end
            FILL: begin
               if (sample_valid) begin
                  ram_we_s = 1'b1;
                  wr_ptr_s = wr_ptr_r + PTR_ONE;
                  cnt_s    = cnt_inc_s;
                  state_s  = (cnt_inc_s == PRETRIG_C) ? ARMED : FILL;
               end else begin
                  state_s = FILL;
               end
            end
            ARMED: begin
               if (sample_valid) begin
                  ram_we_s = 1'b1;
                  wr_ptr_s = wr_ptr_r + PTR_ONE;
               end else begin
                  ram_we_s = 1'b0;
               end
               // A one-sample post window means the trigger sample closes the capture
               if (trig_s) begin
                  triggered_s = 1'b1;
                  if (POST_LEN_C == CNT_ONE) begin
                     state_s   = READOUT;
                     rd_ptr_s  = wr_ptr_s;
                     cnt_s     = CNT_ZERO;
                     rd_pend_s = 1'b0;
                  end else begin
                     state_s = POST;
                     cnt_s   = CNT_ONE;
                  end
               end else begin
                  state_s = ARMED;
               end
            end
            POST: begin
               if (sample_valid) begin
                  ram_we_s = 1'b1;
                  wr_ptr_s = wr_ptr_r + PTR_ONE;
                  cnt_s    = cnt_inc_s;
                  if (cnt_inc_s == POST_LEN_C) begin
                     state_s   = READOUT;
                     rd_ptr_s  = wr_ptr_r + PTR_ONE;
                     cnt_s     = CNT_ZERO;
                     rd_pend_s = 1'b0;
                  end else begin
                     state_s = POST;
                  end
               end else begin
                  state_s = POST;
               end
            end
            READOUT: begin
               if (rd_pend_r) begin
                  out_valid_s = 1'b1;
                  out_data_s  = ram_q_s;
                  rd_pend_s   = 1'b0;
               end else if (!out_valid_r) begin
                  ram_re_s  = 1'b1;
                  rd_pend_s = 1'b1;
               end else if (accept_s) begin
                  rd_ptr_s    = rd_ptr_r + PTR_ONE;
                  cnt_s       = cnt_inc_s;
                  out_valid_s = 1'b0;
                  if (cnt_r == LAST_C) begin
                     state_s     = IDLE;
                     triggered_s = 1'b0;
                  end else begin
                     // Prefetch the next byte in the same cycle the current one is taken
                     ram_re_s    = 1'b1;
                     ram_raddr_s = rd_ptr_r + PTR_ONE;
                     rd_pend_s   = 1'b1;
                  end
               end else begin
                  out_valid_s = out_valid_r;
               end
            end
            default: begin
               state_s     = IDLE;
               triggered_s = 1'b0;
               out_valid_s = 1'b0;
               rd_pend_s   = 1'b0;
            end
         endcase
      end
   end

   // State, pointers and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         wr_ptr_r    <= PTR_ZERO;
         rd_ptr_r    <= PTR_ZERO;
         cnt_r       <= CNT_ZERO;
         prev_any_r  <= 1'b0;
         triggered_r <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= {SAMPLE_W{1'b0}};
         rd_pend_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         wr_ptr_r    <= wr_ptr_s;
         rd_ptr_r    <= rd_ptr_s;
         cnt_r       <= cnt_s;
         prev_any_r  <= sample_valid ? any_s : prev_any_r;
         triggered_r <= triggered_s;
         out_valid_r <= out_valid_s;
         out_data_r  <= out_data_s;
         rd_pend_r   <= rd_pend_s;
         busy_r      <= (state_s != IDLE);
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign busy      = busy_r;
   assign triggered = triggered_r;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with DEPTH=8, PRETRIG=2: reset, trigger,
// backpressure, wrap, zero mask with forced trigger, abort and re-arm.
module tb_capture_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] channel_mask = 8'h01;
   logic       arm = 1'b0;
   logic       abort = 1'b0;
   logic       force_trig = 1'b0;
   logic       sample_valid = 1'b0;
   logic [7:0] sample = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       busy;
   logic       triggered;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q [8];

   capture_sequencer #(.ADDR_W(3), .PRETRIG(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .channel_mask (channel_mask),
      .arm          (arm),
      .abort        (abort),
      .force_trig   (force_trig),
      .sample_valid (sample_valid),
      .sample       (sample),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .busy         (busy),
      .triggered    (triggered)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] v);
      sample       = v;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   // Drains one capture against exp_q; stalls out_ready for 5 cycles from stall_at
   task automatic readout(input string name, input int stall_at);
      int         got = 0;
      int         cyc = 0;
      logic       held = 1'b0;
      logic [7:0] held_d = 8'h00;
      while (got < 8 && cyc < 200) begin
         out_ready = !(cyc >= stall_at && cyc < stall_at + 5);
         if (held && out_valid) chk_eq({name, "_hold"}, out_data, held_d);
         if (out_valid && out_ready) begin
            chk_eq($sformatf("%s_byte%0d", name, got), out_data, exp_q[got]);
            got++;
         end
         held   = out_valid && !out_ready;
         held_d = out_data;
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      chk_eq({name, "_count"}, got, 8);
      chk_eq({name, "_ov_end"}, out_valid, 1'b0);
      chk_eq({name, "_busy_end"}, busy, 1'b0);
      chk_eq({name, "_trig_end"}, triggered, 1'b0);
      tick();
      chk_eq({name, "_no_extra"}, out_valid, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // 1: reset
      tick();
      tick();
      chk_eq("rst_busy", busy, 1'b0);
      chk_eq("rst_ov", out_valid, 1'b0);
      chk_eq("rst_trig", triggered, 1'b0);
      chk_eq("rst_data", out_data, 8'h00);
      rst = 1'b1;
      tick();

      // 2: basic capture; buffer keeps 2 pre-trigger samples, trigger, 5 post
      channel_mask = 8'h01;
      pulse_arm();
      chk_eq("basic_busy", busy, 1'b1);
      send(8'h10); send(8'h11); send(8'h12);
      chk_eq("basic_pretrig", triggered, 1'b0);
      send(8'h13);
      chk_eq("basic_trig", triggered, 1'b1);
      send(8'h14); send(8'h16); send(8'h18); send(8'h1a);
      chk_eq("basic_still_post", out_valid, 1'b0);
      send(8'h1c);
      chk_eq("basic_lat0", out_valid, 1'b0);
      tick();
      chk_eq("basic_lat1", out_valid, 1'b0);
      tick();
      chk_eq("basic_lat2", out_valid, 1'b1);
      exp_q = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      readout("basic", 1000);

      // 3: backpressure mid-readout
      pulse_arm();
      send(8'h01); send(8'h00); send(8'h00); send(8'h03);
      chk_eq("bp_trig", triggered, 1'b1);
      send(8'h01); send(8'h00); send(8'h01); send(8'h00); send(8'h01);
      exp_q = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
      readout("bp", 5);

      // 4: wrap; 20 even samples, forced trigger on a written sample
      channel_mask = 8'hfe;
      pulse_arm();
      for (int i = 0; i < 20; i++) send(8'(2 * i + 2));
      chk_eq("wrap_armed_busy", busy, 1'b1);
      chk_eq("wrap_armed_trig", triggered, 1'b0);
      force_trig = 1'b1;
      send(8'h55);
      force_trig = 1'b0;
      chk_eq("wrap_trig", triggered, 1'b1);
      send(8'h60); send(8'h62); send(8'h64); send(8'h66); send(8'h68);
      exp_q = '{8'h26, 8'h28, 8'h54, 8'h60, 8'h62, 8'h64, 8'h66, 8'h68};
      readout("wrap", 1000);

      // 5: zero mask never self-triggers
      channel_mask = 8'h00;
      pulse_arm();
      for (int i = 0; i < 6; i++) send((i % 2 == 0) ? 8'h00 : 8'hff);
      chk_eq("mask0_trig", triggered, 1'b0);
      chk_eq("mask0_busy", busy, 1'b1);
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      chk_eq("mask0_forced", triggered, 1'b1);
      for (int i = 0; i < 5; i++) send(8'hff);
      exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      readout("mask0", 1000);

      // 6a: arm during POST is ignored and the capture completes
      channel_mask = 8'h01;
      pulse_arm();
      send(8'h00); send(8'h00); send(8'h01);
      send(8'h00); send(8'h01);
      pulse_arm();
      chk_eq("armpost_busy", busy, 1'b1);
      chk_eq("armpost_trig", triggered, 1'b1);
      send(8'h00); send(8'h01); send(8'h00);
      exp_q = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
      readout("armpost", 1000);

      // 6b: abort in POST
      pulse_arm();
      send(8'h00); send(8'h00); send(8'h01); send(8'h00);
      chk_eq("abort_pre_trig", triggered, 1'b1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      out_ready = 1'b1;
      chk_eq("abort_busy", busy, 1'b0);
      chk_eq("abort_trig", triggered, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk_eq("abort_ov", out_valid, 1'b0);
         tick();
      end
      out_ready = 1'b0;

      // 6c: fresh capture after abort
      pulse_arm();
      send(8'h00); send(8'h01); send(8'h00); send(8'h01);
      chk_eq("rearm_trig", triggered, 1'b1);
      send(8'h01); send(8'h00); send(8'h00); send(8'h01); send(8'h01);
      exp_q = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01};
      readout("rearm", 1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
